huffman_decoder: RTL

- Bit-serial canonical-prefix decoder. It is the consumer-side counterpart of the frequency-count and encode path.
- Takes the encoded bitstream MSB-first, matches it against a 10-entry code table for digits 0..9, and emits decoded 4-bit symbols with a valid/ready handshake.
- The code table is written by the host or controller before each run.
- Decoding stops after a programmed symbol count, or on an invalid code.

---
 rtl/huff_pkg.sv | 24 ++
 rtl/huff_code_table.sv | 59 +++++
 rtl/huffman_decoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/huff_pkg.sv
// Shared types and constants for the canonical-prefix Huffman decoder.
// Holds the code-entry layout and the decoder FSM state encoding.
package huff_pkg;

  localparam int NSYM       = 10;
  localparam int SYM_W      = 4;
  localparam int LEN_W      = 4;
  localparam int DEF_MAXLEN = 9;
  // Widest code a LEN_W length field can describe.
  localparam int CODE_W     = (1 << LEN_W) - 1;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
  } code_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

endpackage

// File: rtl/huff_code_table.sv
// 10-entry code table with write port and parallel prefix match.
// The lowest matching symbol index wins.
module huff_code_table
  import huff_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [SYM_W-1:0]  i_sym,
  input  logic [MAXLEN-1:0] i_code,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [MAXLEN-1:0] i_cand,
  input  logic [LEN_W-1:0]  i_cand_len,
  output logic              o_hit,
  output logic [SYM_W-1:0]  o_hit_sym
);

  code_entry_t r_tbl [NSYM];

  logic              w_wr;
  logic [CODE_W-1:0] w_mask;
  logic [CODE_W-1:0] w_cand;

  assign w_wr = i_we
             && (i_sym < SYM_W'(NSYM))
             && (i_len <= LEN_W'(MAXLEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSYM; i++)
        r_tbl[i] <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < NSYM; i++)
        if (i_sym == SYM_W'(i))
          r_tbl[i] <= '{code: CODE_W'(i_code),
                        len:  i_len};
    end
  end

  assign w_mask = ~({CODE_W{1'b1}} << i_cand_len);
  assign w_cand = CODE_W'(i_cand);

  // Walk downwards so the lowest index overwrites.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_sym = '0;
    for (int i = NSYM - 1; i >= 0; i--) begin
      if (r_tbl[i].len != '0
          && r_tbl[i].len == i_cand_len
          && ((r_tbl[i].code ^ w_cand) & w_mask) == '0) begin
        o_hit     = 1'b1;
        o_hit_sym = SYM_W'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Bit-serial canonical-prefix decoder, MSB-first, valid/ready output.
// Per-symbol counters Dnum0..9 built only with HUFF_DEC_STATS_EN.
module huffman_decoder
  import huff_pkg::*;
#(
  parameter int MAXLEN = DEF_MAXLEN,
  parameter int CNT_W  = 8
) (
  input  logic              Clk_in,
  input  logic              nRst,
  input  logic              Tbl_we,
  input  logic [SYM_W-1:0]  Tbl_sym,
  input  logic [MAXLEN-1:0] Tbl_code,
  input  logic [LEN_W-1:0]  Tbl_len,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Sym_total,
  input  logic              Bit_in,
  input  logic              Bit_valid,
  output logic              Bit_ready,
  output logic [SYM_W-1:0]  Sym_out,
  output logic              Sym_valid,
  input  logic              Sym_ready,
  output logic [CNT_W-1:0]  Sym_cnt,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [CNT_W-1:0]  Dnum0,
  output logic [CNT_W-1:0]  Dnum1,
  output logic [CNT_W-1:0]  Dnum2,
  output logic [CNT_W-1:0]  Dnum3,
  output logic [CNT_W-1:0]  Dnum4,
  output logic [CNT_W-1:0]  Dnum5,
  output logic [CNT_W-1:0]  Dnum6,
  output logic [CNT_W-1:0]  Dnum7,
  output logic [CNT_W-1:0]  Dnum8,
  output logic [CNT_W-1:0]  Dnum9
);

  state_t            r_state;
  logic [MAXLEN-1:0] r_acc;
  logic [LEN_W-1:0]  r_acc_len;
  logic [SYM_W-1:0]  r_sym_out;
  logic              r_sym_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_total;
  logic              r_done;
  logic              r_err;

  logic              w_busy;
  logic              w_bit_ready;
  logic              w_accept;
  logic              w_start;
  logic              w_emit;
  logic [MAXLEN-1:0] w_cand;
  logic [LEN_W-1:0]  w_cand_len;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_hit;
  logic [SYM_W-1:0]  w_hit_sym;

  assign w_busy      = (r_state == ST_DECODE);
  assign w_bit_ready = w_busy && (!r_sym_valid || Sym_ready);
  assign w_accept    = Bit_valid && w_bit_ready;
  assign w_start     = Start && !w_busy;
  assign w_emit      = w_accept && w_hit;
  // Oldest accumulated bit falls off; it is never meaningful here.
  assign w_cand      = MAXLEN'({r_acc, Bit_in});
  assign w_cand_len  = r_acc_len + 1'b1;
  assign w_cnt_nxt   = r_cnt + 1'b1;

  huff_code_table #(
    .MAXLEN (MAXLEN)
  ) u_tbl (
    .clk        (Clk_in),
    .rst_n      (nRst),
    .i_we       (Tbl_we && !w_busy),
    .i_sym      (Tbl_sym),
    .i_code     (Tbl_code),
    .i_len      (Tbl_len),
    .i_cand     (w_cand),
    .i_cand_len (w_cand_len),
    .o_hit      (w_hit),
    .o_hit_sym  (w_hit_sym)
  );

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_acc_len   <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_cnt       <= '0;
      r_total     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (r_sym_valid && Sym_ready)
        r_sym_valid <= 1'b0;
      unique case (r_state)
        ST_DECODE: begin
          if (w_emit) begin
            r_sym_out   <= w_hit_sym;
            r_sym_valid <= 1'b1;
            r_acc       <= '0;
            r_acc_len   <= '0;
            r_cnt       <= w_cnt_nxt;
            if (w_cnt_nxt == r_total) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_accept) begin
            if (w_cand_len == LEN_W'(MAXLEN)) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_acc     <= w_cand;
              r_acc_len <= w_cand_len;
            end
          end
        end
        default: begin
          if (w_start) begin
            r_total   <= Sym_total;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_acc_len <= '0;
            r_err     <= 1'b0;
            if (Sym_total == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DECODE;
              r_done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef HUFF_DEC_STATS_EN
  logic [CNT_W-1:0] r_dnum [NSYM];

  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < NSYM; i++)
        r_dnum[i] <= '0;
    end else if (w_start) begin
      for (int i = 0; i < NSYM; i++)
        r_dnum[i] <= '0;
    end else if (w_emit) begin
      for (int i = 0; i < NSYM; i++)
        if (w_hit_sym == SYM_W'(i) && r_dnum[i] != '1)
          r_dnum[i] <= r_dnum[i] + 1'b1;
    end
  end

  assign Dnum0 = r_dnum[0];
  assign Dnum1 = r_dnum[1];
  assign Dnum2 = r_dnum[2];
  assign Dnum3 = r_dnum[3];
  assign Dnum4 = r_dnum[4];
  assign Dnum5 = r_dnum[5];
  assign Dnum6 = r_dnum[6];
  assign Dnum7 = r_dnum[7];
  assign Dnum8 = r_dnum[8];
  assign Dnum9 = r_dnum[9];
`else
  assign Dnum0 = '0;
  assign Dnum1 = '0;
  assign Dnum2 = '0;
  assign Dnum3 = '0;
  assign Dnum4 = '0;
  assign Dnum5 = '0;
  assign Dnum6 = '0;
  assign Dnum7 = '0;
  assign Dnum8 = '0;
  assign Dnum9 = '0;
`endif

  assign Bit_ready = w_bit_ready;
  assign Sym_out   = r_sym_out;
  assign Sym_valid = r_sym_valid;
  assign Sym_cnt   = r_cnt;
  assign Busy      = w_busy;
  assign Done      = r_done;
  assign Err       = r_err;

endmodule
